// File: rtl/x_oneshot_pkg.sv
// Shared definitions for the x_oneshot_n multi-channel one-shot.
// Optional miss detection is enabled with the ONESHOT_MISS_EN macro.
package x_oneshot_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLD    = 2'd2,
        WAITLOW = 2'd3
    } state_t;

    // A programmed width of zero still produces a one-clock pulse.
    function automatic logic [31:0] pulse_width(input logic [31:0] pw);
        return (pw == 32'd0) ? 32'd1 : pw;
    endfunction

endpackage

// File: rtl/x_oneshot_ch.sv
// One one-shot channel: state machine, shared pulse/holdoff counter and
// registered q/busy outputs. With ONESHOT_MISS_EN defined it also keeps a
// sticky flag for rising edges of d that arrive while the channel is
// pulsing or holding off.
module x_oneshot_ch
    import x_oneshot_pkg::*;
#(
    parameter int PWBITS = 4,
    parameter int HOBITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d,
    input  logic [PWBITS-1:0] pw,
    input  logic [HOBITS-1:0] holdoff,
    input  logic              rearm_mode,
`ifdef ONESHOT_MISS_EN
    input  logic              miss_clr,
    output logic              miss,
`endif
    output logic              q,
    output logic              busy
);

    // One counter serves both phases, so it must hold the wider value.
    localparam int CW = (PWBITS > HOBITS) ? PWBITS : HOBITS;

    state_t        state;
    state_t        post_state;
    logic [CW-1:0] cnt;

    // Where the channel goes when the pulse/holdoff sequence completes.
    always_comb begin
        post_state = IDLE;
        if (!rearm_mode && d) begin
            post_state = WAITLOW;
        end
    end

    // Channel state machine; q and busy are registered copies of the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            q    <= (state == PULSE);
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (d) begin
                        state <= PULSE;
                        cnt   <= CW'(pulse_width(32'(pw)));
                    end
                end
                PULSE: begin
                    if (cnt <= CW'(1)) begin
                        if (holdoff != '0) begin
                            state <= HOLD;
                            cnt   <= CW'(holdoff);
                        end else begin
                            state <= post_state;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt <= CW'(1)) begin
                        state <= post_state;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAITLOW: begin
                    if (!d) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef ONESHOT_MISS_EN
    logic d_q;

    // Sticky miss flag: a fresh trigger during PULSE/HOLD is lost; clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_q  <= 1'b0;
            miss <= 1'b0;
        end else begin
            d_q <= d;
            if (miss_clr) begin
                miss <= 1'b0;
            end else if (d && !d_q && (state == PULSE || state == HOLD)) begin
                miss <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/x_oneshot_n.sv
// NCH independent one-shot channels sharing pulse width, holdoff and
// re-arm mode. Define ONESHOT_MISS_EN to add the miss/miss_clr ports.
module x_oneshot_n
    import x_oneshot_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int PWBITS = 4,
    parameter int HOBITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    d,
    input  logic [PWBITS-1:0] pw,
    input  logic [HOBITS-1:0] holdoff,
    input  logic              rearm_mode,
`ifdef ONESHOT_MISS_EN
    input  logic [NCH-1:0]    miss_clr,
    output logic [NCH-1:0]    miss,
`endif
    output logic [NCH-1:0]    q,
    output logic [NCH-1:0]    busy
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        x_oneshot_ch #(
            .PWBITS (PWBITS),
            .HOBITS (HOBITS)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .d          (d[i]),
            .pw         (pw),
            .holdoff    (holdoff),
            .rearm_mode (rearm_mode),
`ifdef ONESHOT_MISS_EN
            .miss_clr   (miss_clr[i]),
            .miss       (miss[i]),
`endif
            .q          (q[i]),
            .busy       (busy[i])
        );
    end

endmodule
